// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int DEFAULT_IDX_W = 3;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one EX operand: EX/MEM beats MEM/WB beats register file.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic [IDX_W-1:0] src_i,
    input  logic             exmem_wr_i,
    input  logic             exmem_load_i,
    input  logic [IDX_W-1:0] exmem_dst_i,
    input  logic             memwb_wr_i,
    input  logic [IDX_W-1:0] memwb_dst_i,
    output logic [1:0]       sel_o
);

    // A load in EX/MEM has no aluOut worth forwarding yet.
    always_comb begin
        if (exmem_wr_i && !exmem_load_i && (exmem_dst_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_wr_i && (memwb_dst_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, stage enables/flushes, EX forwarding and data-memory wait/timeout control.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int IDX_W       = DEFAULT_IDX_W,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] id_Rm,
    input  logic [IDX_W-1:0] id_Rn,
    input  logic [IDX_W-1:0] id_Sm,
    input  logic [IDX_W-1:0] id_Sn,
    input  logic [3:0]       id_src_valid,
    input  logic [IDX_W-1:0] p1_Rm,
    input  logic [IDX_W-1:0] p1_Rn,
    input  logic [IDX_W-1:0] p1_Sm,
    input  logic [IDX_W-1:0] p1_Sn,
    input  logic [IDX_W-1:0] p1_Rd,
    input  logic [IDX_W-1:0] p1_Sd,
    input  logic             p1_memRead,
    input  logic             p1_R_regWrite,
    input  logic             p1_S_regWrite,
    input  logic [IDX_W-1:0] p2_Rd,
    input  logic [IDX_W-1:0] p2_Sd,
    input  logic             p2_R_regWrite,
    input  logic             p2_S_regWrite,
    input  logic             p2_memRead,
    input  logic             p2_memWrite,
    input  logic             p2_branch_taken,
    input  logic [IDX_W-1:0] p3_Rd,
    input  logic [IDX_W-1:0] p3_Sd,
    input  logic             p3_R_regWrite,
    input  logic             p3_S_regWrite,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_Rm,
    output logic [1:0]       fwd_Rn,
    output logic [1:0]       fwd_Sm,
    output logic [1:0]       fwd_Sn,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MEM_TIMEOUT);

    ctrl_state_e      state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic mem_busy;
    logic load_use;
    logic stall_inc;

    assign mem_busy = (p2_memRead | p2_memWrite) & ~mem_ready;

    assign load_use = p1_memRead & (
        (p1_R_regWrite & ((id_src_valid[0] & (p1_Rd == id_Rm)) |
                          (id_src_valid[1] & (p1_Rd == id_Rn)))) |
        (p1_S_regWrite & ((id_src_valid[2] & (p1_Sd == id_Sm)) |
                          (id_src_valid[3] & (p1_Sd == id_Sn)))));

    // Forwarding: slots 0/1 use the R file, slots 2/3 the S file.
    logic [IDX_W-1:0] fwd_src [4];
    logic [1:0]       fwd_sel [4];

    assign fwd_src[0] = p1_Rm;
    assign fwd_src[1] = p1_Rn;
    assign fwd_src[2] = p1_Sm;
    assign fwd_src[3] = p1_Sn;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
            localparam bit IS_S = (gi >= 2);
            pipe_fwd_sel #(.IDX_W(IDX_W)) u_sel (
                .src_i        (fwd_src[gi]),
                .exmem_wr_i   (IS_S ? p2_S_regWrite : p2_R_regWrite),
                .exmem_load_i (p2_memRead),
                .exmem_dst_i  (IS_S ? p2_Sd : p2_Rd),
                .memwb_wr_i   (IS_S ? p3_S_regWrite : p3_R_regWrite),
                .memwb_dst_i  (IS_S ? p3_Sd : p3_Rd),
                .sel_o        (fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_Rm = reset ? FWD_RF : fwd_sel[0];
    assign fwd_Rn = reset ? FWD_RF : fwd_sel[1];
    assign fwd_Sm = reset ? FWD_RF : fwd_sel[2];
    assign fwd_Sn = reset ? FWD_RF : fwd_sel[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    wait_cnt_d = WC_ONE;
                    state_d    = (WC_ONE >= WC_LIMIT) ? ST_FAULT : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_ONE;
                    if (wait_cnt_d >= WC_LIMIT) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_busy) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_we     = 1'b0;
                        exmem_we    = 1'b0;
                        memwb_flush = 1'b1;
                    end else if (p2_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_we     = 1'b0;
                        exmem_we    = 1'b0;
                        memwb_flush = 1'b1;
                    end
                end
                default: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                    memwb_we = 1'b0;
                end
            endcase
        end
    end

    assign stall_inc = ~pc_we & (state_q != ST_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            timeout_q <= timeout_q | (state_d == ST_FAULT);
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;

endmodule
